uart_cmd_assembler: RTL and testbench

//  Sits directly downstream of the UART receiver. Consumes its byte stream (rx_data/rdy),

---
 rtl/uart_cmd_pkg.sv | 14 +
 rtl/uart_gap_timer.sv | 31 +++
 rtl/uart_cmd_assembler.sv | 116 +++++++++++
 tb/tb_uart_cmd_assembler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and default widths for the UART command path.
// The command processor uses the same defaults.
package uart_cmd_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } asm_state_t;

    localparam int unsigned CMD_W           = 16;
    localparam int unsigned CMD_BYTES_DEF   = CMD_W / 8;
    localparam int unsigned TIMEOUT_CYC_DEF = 100000;

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts enabled cycles and flags the last one before timeout.
// Restarts on clr or on expiry, so the count never wraps.
module uart_gap_timer #(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] r_cnt;

    // A clear in the same cycle suppresses expiry.
    assign o_expired = i_en && !i_clr && (r_cnt == LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_expired) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/uart_cmd_assembler.sv
// Packs UART receiver bytes (MSB first) into command words with a ready/clear
// handshake, discarding partial commands after an inter-byte timeout.
module uart_cmd_assembler
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CMD_BYTES   = CMD_BYTES_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_rdy,
    output logic                   o_clr_rx_rdy,
    output logic [8*CMD_BYTES-1:0] o_cmd,
    output logic                   o_cmd_rdy,
    input  logic                   i_clr_cmd_rdy,
    output logic                   o_timeout_err,
    output logic                   o_overrun,
    input  logic                   i_clr_err
);

    localparam int unsigned CW = 8 * CMD_BYTES;
    localparam int unsigned BW = $clog2(CMD_BYTES + 1);

    asm_state_t    r_state, w_state_nxt;
    logic [BW-1:0] r_byte_cnt, w_byte_cnt_nxt;
    // Only the bytes preceding the final one need storage; the top byte would never be read.
    logic [CW-9:0] r_asm;
    logic [CW-1:0] r_cmd;
    logic          r_cmd_rdy;
    logic          r_overrun;

    logic          w_capture;
    logic          w_complete;
    logic          w_expired;
    logic [CW-1:0] w_shifted;

    assign w_capture  = i_rx_rdy && !i_rst;
    assign w_shifted  = {r_asm, i_rx_data};
    assign w_complete = w_capture && (r_byte_cnt == BW'(CMD_BYTES - 1));

    uart_gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (w_capture || (r_state != COLLECT)),
        .i_en      (r_state == COLLECT),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_byte_cnt_nxt = r_byte_cnt;
        case (r_state)
            IDLE: begin
                if (w_capture) begin
                    w_state_nxt    = COLLECT;
                    w_byte_cnt_nxt = r_byte_cnt + BW'(1);
                end
            end
            COLLECT: begin
                if (w_complete) begin
                    w_state_nxt    = IDLE;
                    w_byte_cnt_nxt = '0;
                end else if (w_capture) begin
                    w_byte_cnt_nxt = r_byte_cnt + BW'(1);
                end else if (w_expired) begin
                    w_state_nxt    = IDLE;
                    w_byte_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_byte_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_cmd      <= '0;
            r_cmd_rdy  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            if (w_capture) begin
                r_asm <= w_shifted[CW-9:0];
            end
            if (w_complete) begin
                r_cmd <= w_shifted;
            end
            if (w_complete) begin
                r_cmd_rdy <= 1'b1;
            end else if (i_clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end
            if (w_complete && r_cmd_rdy && !i_clr_cmd_rdy) begin
                r_overrun <= 1'b1;
            end else if (i_clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_clr_rx_rdy  = w_capture;
    assign o_cmd         = r_cmd;
    assign o_cmd_rdy     = r_cmd_rdy;
    assign o_timeout_err = w_expired;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler with a queue-based reference model
// checked every cycle, plus literal expectations per scenario.
module tb_uart_cmd_assembler;

    localparam int unsigned CB = 2;
    localparam int unsigned CW = 8 * CB;
    localparam int unsigned T  = 26040;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_rdy = 1'b0;
    logic          clr_rx_rdy;
    logic [CW-1:0] cmd;
    logic          cmd_rdy;
    logic          clr_cmd_rdy = 1'b0;
    logic          timeout_err;
    logic          overrun;
    logic          clr_err = 1'b0;

    int total = 0;
    int bad   = 0;
    int clr_cnt = 0;
    int tmo_cnt = 0;

    uart_cmd_assembler #(
        .CMD_BYTES   (CB),
        .TIMEOUT_CYC (T)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_rx_data     (rx_data),
        .i_rx_rdy      (rx_rdy),
        .o_clr_rx_rdy  (clr_rx_rdy),
        .o_cmd         (cmd),
        .o_cmd_rdy     (cmd_rdy),
        .i_clr_cmd_rdy (clr_cmd_rdy),
        .o_timeout_err (timeout_err),
        .o_overrun     (overrun),
        .i_clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes held so far, silent cycles since last byte, outputs.
    logic [7:0]    q[$];
    int unsigned   gap = 0;
    logic [CW-1:0] m_cmd = '0;
    logic          m_rdy = 1'b0;
    logic          m_ovr = 1'b0;

    always @(negedge clk) begin
        logic e_clr, e_tmo, comp;
        if (rst) begin
            q.delete();
            gap   = 0;
            m_cmd = '0;
            m_rdy = 1'b0;
            m_ovr = 1'b0;
        end
        e_clr = !rst && rx_rdy;
        e_tmo = !rst && !rx_rdy && (q.size() > 0) && (gap == T - 1);
        chk("clr_rx_rdy", 32'(clr_rx_rdy), 32'(e_clr));
        chk("timeout_err", 32'(timeout_err), 32'(e_tmo));
        chk("cmd", 32'(cmd), 32'(m_cmd));
        chk("cmd_rdy", 32'(cmd_rdy), 32'(m_rdy));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (clr_rx_rdy) clr_cnt++;
        if (timeout_err) tmo_cnt++;
        if (!rst) begin
            comp = rx_rdy && (q.size() == CB - 1);
            if (comp && m_rdy && !clr_cmd_rdy) m_ovr = 1'b1;
            else if (clr_err) m_ovr = 1'b0;
            if (comp) m_rdy = 1'b1;
            else if (clr_cmd_rdy) m_rdy = 1'b0;
            if (rx_rdy) begin
                q.push_back(rx_data);
                gap = 0;
                if (q.size() == CB) begin
                    m_cmd = '0;
                    foreach (q[i]) m_cmd = {m_cmd[CW-9:0], q[i]};
                    q.delete();
                end
            end else if (q.size() > 0) begin
                if (gap == T - 1) begin
                    q.delete();
                    gap = 0;
                end else begin
                    gap++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Receiver stub: hold rdy until acked, then drop it after the next edge.
    task automatic send_byte(input logic [7:0] b, input logic with_clr);
        bit seen = 0;
        rx_data = b;
        rx_rdy  = 1'b1;
        clr_cmd_rdy = with_clr;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (clr_rx_rdy) seen = 1;
        end
        if (!seen) chk("byte_ack_wait", 32'(0), 32'(1));
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
        clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        int c0, t0;
        tick(3);
        chk("reset_cmd", 32'(cmd), 32'h0);
        chk("reset_cmd_rdy", 32'(cmd_rdy), 32'h0);
        rst = 1'b0;
        tick(2);

        // 1: bytes spaced exactly the timeout distance; the capture wins
        c0 = clr_cnt; t0 = tmo_cnt;
        send_byte(8'hA5, 1'b0);
        tick(T - 1);
        send_byte(8'h3C, 1'b0);
        chk("t1_cmd", 32'(cmd), 32'hA53C);
        chk("t1_cmd_rdy", 32'(cmd_rdy), 32'h1);
        chk("t1_clr_pulses", 32'(clr_cnt - c0), 32'd2);
        chk("t1_no_timeout", 32'(tmo_cnt - t0), 32'd0);

        // 2: overrun then clear
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        chk("t2_cmd", 32'(cmd), 32'h1234);
        chk("t2_overrun", 32'(overrun), 32'h1);
        clr_err = 1'b1; tick(1); clr_err = 1'b0;
        chk("t2_overrun_clr", 32'(overrun), 32'h0);

        // 3: partial command timeout
        clr_cmd_rdy = 1'b1; tick(1); clr_cmd_rdy = 1'b0;
        chk("t3_rdy_cleared", 32'(cmd_rdy), 32'h0);
        chk("t3_cmd_held", 32'(cmd), 32'h1234);
        t0 = tmo_cnt;
        send_byte(8'h55, 1'b0);
        tick(T);
        chk("t3_timeouts", 32'(tmo_cnt - t0), 32'd1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        chk("t3_cmd", 32'(cmd), 32'h0102);
        chk("t3_overrun", 32'(overrun), 32'h0);

        // 4: completion coincident with consumer ack
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b1);
        chk("t4_cmd", 32'(cmd), 32'h7788);
        chk("t4_cmd_rdy", 32'(cmd_rdy), 32'h1);
        chk("t4_overrun", 32'(overrun), 32'h0);

        // 5: reset mid-command; rx_rdy during reset is ignored
        send_byte(8'hFF, 1'b0);
        rst = 1'b1;
        rx_data = 8'h99; rx_rdy = 1'b1;
        tick(1);
        chk("t5_clr_in_rst", 32'(clr_rx_rdy), 32'h0);
        chk("t5_cmd", 32'(cmd), 32'h0);
        chk("t5_cmd_rdy", 32'(cmd_rdy), 32'h0);
        chk("t5_overrun", 32'(overrun), 32'h0);
        chk("t5_timeout", 32'(timeout_err), 32'h0);
        rx_rdy = 1'b0; rst = 1'b0;
        tick(1);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b0);
        chk("t5_beef", 32'(cmd), 32'hBEEF);

        // 6: receiver ignoring the ack holds rdy for three cycles
        clr_cmd_rdy = 1'b1; tick(1); clr_cmd_rdy = 1'b0;
        c0 = clr_cnt;
        rx_data = 8'h11; rx_rdy = 1'b1; tick(1);
        rx_data = 8'h22; tick(1);
        rx_data = 8'h33; tick(1);
        rx_rdy = 1'b0;
        chk("t6_captures", 32'(clr_cnt - c0), 32'd3);
        chk("t6_cmd", 32'(cmd), 32'h1122);
        chk("t6_cmd_rdy", 32'(cmd_rdy), 32'h1);
        tick(2);
        send_byte(8'h44, 1'b0);
        chk("t6_cmd2", 32'(cmd), 32'h3344);
        chk("t6_overrun", 32'(overrun), 32'h1);

        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
